mdu_iterative: RTL and testbench
================================

# mdu_iterative

Iterative multiply/divide unit for the Execute stage, running beside the single-cycle ALU to add the RV32M operations. It accepts one operation per start pulse, computes over several cycles with a shift-add multiplier or a restoring divider, and returns one result with a done pulse. `BusyE` stalls the pipeline front end while an operation is in flight. The unit is parametrised in data width.

## Interface
- `DATA_WIDTH`, 32, operand/result width; even, ≥ 8
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `StartE` in 1: launch an operation with the current operands/control
- `MDUctrlE` in 3: op select, RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
- `SrcAE` in DATA_WIDTH: rs1 operand (dividend / multiplicand)
- `SrcBE` in DATA_WIDTH: rs2 operand (divisor / multiplier)
- `FlushE` in 1: abort any operation in flight
- `BusyE` out 1: operation in flight; stall request
- `DoneE` out 1: one-cycle pulse, `MDUout` valid
- `MDUout` out DATA_WIDTH: result, held until the next completion

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `StartE`=1:
  - Latch op and operands.
  - Take absolute values for signed ops: MULH/DIV/REM both operands; MULHSU `SrcAE` only.
  - Record the result sign.
  - Load iteration counter = DATA_WIDTH.
  - Go to CALC.
- Special divide cases skip CALC and go IDLE→DONE directly:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = −1): quotient = dividend; remainder = 0.
- CALC, multiply: one shift-add step per cycle into a 2·DATA_WIDTH product register.
- CALC, divide: one restoring step per cycle into quotient/remainder registers.
- Counter decrements each CALC cycle. On the step where the counter reaches 0, apply sign fixup (two's-complement negate if the recorded sign is negative) and go to DONE.
- Result selection:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
- DONE: `DoneE`=1 and `MDUout` updated. Next state is IDLE, or CALC if `StartE`=1 (back-to-back; new operands latched that cycle).
- `StartE` in CALC is ignored.
- `FlushE`=1 in any state: next state IDLE; no `DoneE`; `MDUout` unchanged. Flush takes priority over a simultaneous Start.
- Arithmetic is modulo 2^DATA_WIDTH. No exceptions are raised.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, counter 0, `BusyE`=0, `DoneE`=0, `MDUout`=0, all internal registers 0.
- Reset mid-operation discards the operation; no `DoneE` is produced.
- `BusyE` = 1 exactly while the state is CALC. It is registered and rises the cycle after Start is sampled.
- Normal latency: Start sampled at edge T0; CALC occupies edges T1..T_DATA_WIDTH; `DoneE` high during the cycle after edge T_DATA_WIDTH (DATA_WIDTH+1 cycles from Start to Done).
- Special divide cases: `DoneE` high the cycle after the Start edge (latency 1).
- Throughput: one operation per DATA_WIDTH+1 cycles with back-to-back Start in DONE.
- Operands are sampled only at Start. Input changes during CALC have no effect.

## Configuration
- `MDU_DIV_EN` defined: the divider datapath and all DIV/DIVU/REM/REMU behaviour above are built.
- `MDU_DIV_EN` undefined: no divider logic is built. Ops 1xx complete with latency 1 (IDLE→DONE) and `MDUout` = 0. Multiply ops are unaffected.

## Test plan
- Reset: assert `rst_n`=0 mid-CALC → `BusyE`=0, `DoneE`=0, `MDUout`=0 immediately; no Done follows after release.
- MUL / MULHU, W=32: MUL 0x0000_1234 × 0x0000_0010 → `MDUout`=0x0001_2340, `DoneE` 33 cycles after Start. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- Signed multiply high: MULH 0xFFFF_FFFF (−1) × 0x0000_0002 → 0xFFFF_FFFF. MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF.
- Signed divide: DIV −7 ÷ 2 → 0xFFFF_FFFD (−3); REM −7 ÷ 2 → 0xFFFF_FFFF (−1). DIVU 100 ÷ 7 → 14; REMU 100 ÷ 7 → 2.
- Divide corner cases, `DoneE` the cycle after Start:
  - DIVU 5 ÷ 0 → 0xFFFF_FFFF; REMU 5 ÷ 0 → 5.
  - DIV 0x8000_0000 ÷ 0xFFFF_FFFF → 0x8000_0000; REM of the same → 0.
- Control:
  - Start held during CALC → single Done.
  - Start in DONE → second result 33 cycles later.
  - `FlushE` at CALC cycle 10 → IDLE, no Done, `MDUout` keeps its previous value.
  - Flush and Start together → remains IDLE.
  - Repeat with `MDU_DIV_EN` undefined: DIV → `MDUout`=0, latency 1.

Source files
------------

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV32M multiply/divide unit for the Execute stage.
// Multiplies with a radix-2 shift-add loop, divides with a restoring loop,
// both on magnitudes with a sign fixup on the final step.
// Build option: define MDU_DIV_EN to include the divider; without it the
// 1xx ops complete in one cycle with a zero result.
`default_nettype none

module mdu_iterative #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StartE,
  input  logic [2:0]            MDUctrlE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  FlushE,
  output logic                  BusyE,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] MDUout
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negate of a result-width value.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return '0 - x;
  endfunction

  // Multiply result: optional negate of the full product, then pick a half.
  // sel 00 is MUL (low half); every other multiply op returns the high half.
  function automatic logic [W-1:0] mul_result(input logic [2*W-1:0] p,
                                              input logic           neg,
                                              input logic [1:0]     sel);
    logic [2*W-1:0] pf;
    pf = neg ? ('0 - p) : p;
    return (sel == 2'b00) ? pf[W-1:0] : pf[2*W-1:W];
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    out_q, out_d;

  // Launch-time operand conditioning
  logic            signed_a, signed_b;
  logic            sign_a, sign_b;
  logic [W-1:0]    abs_a, abs_b;
  logic            launch_neg;
  logic            launch_fast;
  logic [W-1:0]    fast_res;

  // Per-cycle iteration results
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_acc;
  logic [2*W-1:0]  step_acc;
  logic [W-1:0]    final_res;

  assign BusyE  = busy_q;
  assign DoneE  = done_q;
  assign MDUout = out_q;

  // Operand signs and magnitudes for the op presented at Start
  always_comb begin
    signed_a   = (MDUctrlE == OP_MULH) || (MDUctrlE == OP_MULHSU) ||
                 (MDUctrlE == OP_DIV)  || (MDUctrlE == OP_REM);
    signed_b   = (MDUctrlE == OP_MULH) || (MDUctrlE == OP_DIV) ||
                 (MDUctrlE == OP_REM);
    sign_a     = signed_a & SrcAE[W-1];
    sign_b     = signed_b & SrcBE[W-1];
    abs_a      = sign_a ? neg_w(SrcAE) : SrcAE;
    abs_b      = sign_b ? neg_w(SrcBE) : SrcBE;
    // Quotient and MULH take the XOR of signs; remainder and MULHSU follow rs1.
    case (MDUctrlE)
      OP_MULH, OP_DIV:   launch_neg = sign_a ^ sign_b;
      OP_MULHSU, OP_REM: launch_neg = sign_a;
      default:           launch_neg = 1'b0;
    endcase
  end

`ifdef MDU_DIV_EN
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic            div_zero, div_ovf;
  logic [W:0]      div_sh;
  logic            div_ge;
  logic [W-1:0]    div_rem;
  logic [2*W-1:0]  div_acc;
  logic [W-1:0]    div_sel;

  // Divide corner cases resolved at launch without iterating
  always_comb begin
    div_zero    = MDUctrlE[2] && (SrcBE == '0);
    div_ovf     = MDUctrlE[2] && !MDUctrlE[0] &&
                  (SrcAE == MOST_NEG) && (SrcBE == '1);
    launch_fast = div_zero || div_ovf;
    if (div_zero) fast_res = MDUctrlE[1] ? SrcAE : '1;
    else          fast_res = MDUctrlE[1] ? '0 : SrcAE;
  end

  // One restoring-division step: acc = {remainder, dividend/quotient}
  always_comb begin
    div_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    // When the trial subtract succeeds the true difference is below the
    // divisor, so the modulo-W subtract is exact.
    div_rem = div_ge ? (div_sh[W-1:0] - opnd_q) : div_sh[W-1:0];
    div_acc = {div_rem, acc_q[W-2:0], div_ge};
  end
`else
  // Without a divider every 1xx op completes immediately with zero.
  always_comb begin
    launch_fast = MDUctrlE[2];
    fast_res    = '0;
  end
`endif

  // One shift-add multiply step: acc = {partial high, remaining multiplier}
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc = {mul_sum, acc_q[W-1:1]};
  end

  // Select the step for the op in flight and form the final signed result
  always_comb begin
`ifdef MDU_DIV_EN
    step_acc  = op_q[2] ? div_acc : mul_acc;
    div_sel   = op_q[1] ? div_acc[2*W-1:W] : div_acc[W-1:0];
    final_res = op_q[2] ? (neg_q ? neg_w(div_sel) : div_sel)
                        : mul_result(mul_acc, neg_q, op_q[1:0]);
`else
    step_acc  = mul_acc;
    final_res = op_q[2] ? '0 : mul_result(mul_acc, neg_q, op_q[1:0]);
`endif
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    out_d   = out_q;

    case (state_q)
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = step_acc;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          out_d   = final_res;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (StartE) begin
          op_d  = MDUctrlE;
          neg_d = launch_neg;
          if (launch_fast) begin
            state_d = DONE;
            cnt_d   = '0;
            out_d   = fast_res;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(W);
            if (MDUctrlE[2]) begin
              opnd_d = abs_b;
              acc_d  = {{W{1'b0}}, abs_a};
            end else begin
              opnd_d = abs_a;
              acc_d  = {{W{1'b0}}, abs_b};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a simultaneous Start.
    if (FlushE) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = out_q;
    end

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative (DATA_WIDTH = 32).
module tb_mdu_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         StartE;
  logic [2:0]   MDUctrlE;
  logic [W-1:0] SrcAE;
  logic [W-1:0] SrcBE;
  logic         FlushE;
  logic         BusyE;
  logic         DoneE;
  logic [W-1:0] MDUout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StartE   (StartE),
    .MDUctrlE (MDUctrlE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .FlushE   (FlushE),
    .BusyE    (BusyE),
    .DoneE    (DoneE),
    .MDUout   (MDUout)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op, scramble operands afterwards, wait (bounded) for Done.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    MDUctrlE = op; SrcAE = a; SrcBE = b; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    lat = 1;
    check({tag, " busy"}, W'(BusyE), (exp_lat > 1) ? 32'd1 : 32'd0);
    SrcAE = ~a; SrcBE = b + 32'd3; MDUctrlE = ~op;
    while (!DoneE && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " result"}, MDUout, exp);
    @(negedge clk);
    check({tag, " done pulse"}, W'(DoneE), 32'd0);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (DoneE) cnt++;
    end
  endtask

  initial begin
    int n;
    int lat;
    rst_n = 1'b0; StartE = 1'b0; FlushE = 1'b0;
    MDUctrlE = 3'b000; SrcAE = '0; SrcBE = '0;

    // Reset state
    @(negedge clk);
    check("reset busy", W'(BusyE), 32'd0);
    check("reset done", W'(DoneE), 32'd0);
    check("reset out", MDUout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply
    run_op("mul",      3'b000, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 33);
    run_op("mul neg",  3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 33);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",     3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    run_op("mulh min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

`ifdef MDU_DIV_EN
    run_op("div",       3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    run_op("rem",       3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    run_op("divu",      3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu",      3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu by 0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu by 0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("div by 0",  3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem by 0",  3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op("div ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
`else
    run_op("div off",  3'b100, 32'd7, 32'd2, 32'd0, 1);
    run_op("remu off", 3'b111, 32'd100, 32'd7, 32'd0, 1);
    run_op("mul after div off", 3'b000, 32'd9, 32'd9, 32'd81, 33);
`endif

    // Start held across CALC: only one completion
    @(negedge clk);
    MDUctrlE = 3'b000; SrcAE = 32'd7; SrcBE = 32'd6; StartE = 1'b1;
    repeat (10) @(negedge clk);
    StartE = 1'b0;
    count_done(40, n);
    check("held start dones", W'(n), 32'd1);
    check("held start result", MDUout, 32'd42);

    // Back-to-back: new Start while DONE
    @(negedge clk);
    MDUctrlE = 3'b000; SrcAE = 32'h0000_1234; SrcBE = 32'h0000_0010; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    lat = 1;
    while (!DoneE && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b first result", MDUout, 32'h0001_2340);
    MDUctrlE = 3'b011; SrcAE = 32'hFFFF_FFFF; SrcBE = 32'hFFFF_FFFF; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    lat = 1;
    check("b2b busy", W'(BusyE), 32'd1);
    while (!DoneE && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b latency", W'(lat), 32'd33);
    check("b2b second result", MDUout, 32'hFFFF_FFFE);

    // Flush mid-CALC: no Done, output keeps the previous result
    @(negedge clk);
    MDUctrlE = 3'b000; SrcAE = 32'd3; SrcBE = 32'd4; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    repeat (9) @(negedge clk);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    check("flush busy", W'(BusyE), 32'd0);
    count_done(40, n);
    check("flush dones", W'(n), 32'd0);
    check("flush out held", MDUout, 32'hFFFF_FFFE);

    // Flush together with Start: stays idle
    @(negedge clk);
    MDUctrlE = 3'b000; SrcAE = 32'd5; SrcBE = 32'd5; StartE = 1'b1; FlushE = 1'b1;
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    check("flush+start busy", W'(BusyE), 32'd0);
    count_done(40, n);
    check("flush+start dones", W'(n), 32'd0);
    check("flush+start out", MDUout, 32'hFFFF_FFFE);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    MDUctrlE = 3'b000; SrcAE = 32'd11; SrcBE = 32'd13; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", W'(BusyE), 32'd0);
    check("async reset done", W'(DoneE), 32'd0);
    check("async reset out", MDUout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, n);
    check("post reset dones", W'(n), 32'd0);
    check("post reset out", MDUout, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
